// File: rtl/mole_game_ctrl.sv
// Whack-a-mole sequencer: LFSR mole picker, tick timing, hit/miss judging.
// Define SPEEDUP_EN to shrink the mole window on every hit.
module mole_game_ctrl #(
    parameter int unsigned TICK_DIV     = 50_000,
    parameter int unsigned UP_TICKS     = 1000,
    parameter int unsigned GAP_TICKS    = 400,
    parameter int unsigned MAX_MISSES   = 5,
    parameter int unsigned MIN_UP_TICKS = 300,
    parameter int unsigned SPEED_STEP   = 50
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       start,
    input  logic [3:0] hit_btn,
    output logic [3:0] LEDR,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0] UP_INIT = 16'(UP_TICKS);
    localparam logic [15:0] GAP_INIT = 16'(GAP_TICKS);
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

    if (MIN_UP_TICKS > UP_TICKS || SPEED_STEP > 65535) begin : g_bad_cfg
        $error("mole_game_ctrl: window floor/step out of range");
    end

    typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_e;

    state_e         state_q;
    logic [TW-1:0]  tick_cnt_q;
    logic [15:0]    timer_q;
    logic [15:0]    window_q;
    logic [15:0]    window_d;
    logic [3:0]     lfsr_q;
    logic [3:0]     lfsr_d;
    logic [3:0]     led_q;
    logic [7:0]     score_q;
    logic [7:0]     score_d;
    logic [3:0]     misses_q;
    logic [3:0]     misses_d;
    logic           over_q;

    logic           start_meta_q, start_sync_q, start_prev_q;
    logic [3:0]     hit_meta_q, hit_sync_q, hit_prev_q;
    logic           start_edge;
    logic [3:0]     hit_edge;
    logic           tick;
    logic           timer_done;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            hit_meta_q   <= '0;
            hit_sync_q   <= '0;
            hit_prev_q   <= '0;
        end else begin
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            hit_meta_q   <= hit_btn;
            hit_sync_q   <= hit_meta_q;
            hit_prev_q   <= hit_sync_q;
        end
    end

    assign start_edge = start_sync_q & ~start_prev_q;
    assign hit_edge   = hit_sync_q & ~hit_prev_q;
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign timer_done = tick && (timer_q == 16'd1);

    assign lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    assign misses_d = misses_q + 4'd1;

`ifdef SPEEDUP_EN
    // Compare before subtracting so the window can never wrap below the floor.
    localparam logic [16:0] SHRINK_MIN = 17'(MIN_UP_TICKS) + 17'(SPEED_STEP);
    assign window_d = ({1'b0, window_q} >= SHRINK_MIN)
                    ? window_q - 16'(SPEED_STEP)
                    : 16'(MIN_UP_TICKS);
`else
    assign window_d = window_q;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            timer_q    <= '0;
            window_q   <= UP_INIT;
            lfsr_q     <= 4'b0001;
            led_q      <= '0;
            score_q    <= '0;
            misses_q   <= '0;
            over_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            unique case (state_q)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state_q    <= GAP;
                        score_q    <= '0;
                        misses_q   <= '0;
                        window_q   <= UP_INIT;
                        timer_q    <= GAP_INIT;
                        tick_cnt_q <= '0;
                        led_q      <= '0;
                        over_q     <= 1'b0;
                    end
                end
                GAP: begin
                    if (timer_done) begin
                        state_q    <= UP;
                        lfsr_q     <= lfsr_d;
                        led_q      <= 4'b0001 << lfsr_d[1:0];
                        timer_q    <= window_q;
                        tick_cnt_q <= '0;
                    end else if (tick) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                UP: begin
                    // A clean hit wins even if the window expires this cycle.
                    if (hit_edge == led_q) begin
                        score_q    <= score_d;
                        window_q   <= window_d;
                        state_q    <= GAP;
                        timer_q    <= GAP_INIT;
                        tick_cnt_q <= '0;
                        led_q      <= '0;
                    end else if (hit_edge != '0 || timer_done) begin
                        misses_q   <= misses_d;
                        tick_cnt_q <= '0;
                        if (misses_d == MISS_LIMIT) begin
                            state_q <= OVER;
                            led_q   <= 4'b1111;
                            over_q  <= 1'b1;
                        end else begin
                            state_q <= GAP;
                            timer_q <= GAP_INIT;
                            led_q   <= '0;
                        end
                    end else if (tick) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LEDR      = led_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: sequencing, hits, misses, game over.
// Fast timing parameters; window model follows SPEEDUP_EN when defined.
module tb_mole_game_ctrl;

    localparam int TD    = 4;
    localparam int GAPT  = 2;
    localparam int MAXM  = 2;
    localparam int MINUP = 3;
    localparam int STEP  = 4;
`ifdef SPEEDUP_EN
    localparam int UPT = 10;
`else
    localparam int UPT = 3;
`endif
    localparam int GAPC = GAPT * TD;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] hit_btn;
    logic [3:0] LEDR;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int exp_win = UPT;

    mole_game_ctrl #(
        .TICK_DIV    (TD),
        .UP_TICKS    (UPT),
        .GAP_TICKS   (GAPT),
        .MAX_MISSES  (MAXM),
        .MIN_UP_TICKS(MINUP),
        .SPEED_STEP  (STEP)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .start    (start),
        .hit_btn  (hit_btn),
        .LEDR     (LEDR),
        .score    (score),
        .misses   (misses),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic upd_win();
`ifdef SPEEDUP_EN
        exp_win = (exp_win >= MINUP + STEP) ? exp_win - STEP : MINUP;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; hit_btn = 4'b0000;
        step(2);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL rst_led got %b exp 0000", LEDR); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d exp 0", score); end
        checks++; if (misses !== 4'd0) begin errors++; $display("FAIL rst_misses got %0d exp 0", misses); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_over got %b exp 0", game_over); end
        rst_n = 1'b1;
        step(20);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL idle_led got %b exp 0000", LEDR); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL idle_over got %b exp 0", game_over); end
    endtask

    task automatic test_mole_sequence();
        start = 1'b1; exp_win = UPT;
        step(3);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL gap1_led got %b exp 0000", LEDR); end
        step(GAPC - 1);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL gap1_end got %b exp 0000", LEDR); end
        step(1);
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL mole1 got %b exp 0100", LEDR); end
        step(exp_win * TD - 1);
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL mole1_hold got %b exp 0100", LEDR); end
        checks++; if (misses !== 4'd0) begin errors++; $display("FAIL mole1_miss got %0d exp 0", misses); end
        step(1);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL to1_led got %b exp 0000", LEDR); end
        checks++; if (misses !== 4'd1) begin errors++; $display("FAIL to1_miss got %0d exp 1", misses); end
        step(GAPC);
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL mole2 got %b exp 0001", LEDR); end
    endtask

    task automatic test_game_over();
        step(exp_win * TD);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_flag got %b exp 1", game_over); end
        checks++; if (LEDR !== 4'b1111) begin errors++; $display("FAIL go_led got %b exp 1111", LEDR); end
        checks++; if (misses !== 4'd2) begin errors++; $display("FAIL go_miss got %0d exp 2", misses); end
        step(20);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_stay got %b exp 1", game_over); end
        start = 1'b0; step(3);
        start = 1'b1; exp_win = UPT; step(3);
        checks++; if (misses !== 4'd0) begin errors++; $display("FAIL rs_miss got %0d exp 0", misses); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rs_score got %0d exp 0", score); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rs_over got %b exp 0", game_over); end
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL rs_led got %b exp 0000", LEDR); end
        step(GAPC);
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL mole3 got %b exp 0010", LEDR); end
    endtask

    task automatic test_hit();
        hit_btn = 4'b0010;
        step(3);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL hit_score got %0d exp 1", score); end
        checks++; if (misses !== 4'd0) begin errors++; $display("FAIL hit_miss got %0d exp 0", misses); end
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL hit_led got %b exp 0000", LEDR); end
        upd_win();
        hit_btn = 4'b0000;
        step(GAPC);
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL mole4 got %b exp 1000", LEDR); end
    endtask

    task automatic test_wrong_press();
        hit_btn = 4'b0001;
        step(3);
        checks++; if (misses !== 4'd1) begin errors++; $display("FAIL wrong_miss got %0d exp 1", misses); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL wrong_score got %0d exp 1", score); end
        hit_btn = 4'b0000;
        step(GAPC);
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL mole5 got %b exp 0100", LEDR); end
        hit_btn = 4'b1111;
        step(3);
        checks++; if (misses !== 4'd2) begin errors++; $display("FAIL multi_miss got %0d exp 2", misses); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL multi_score got %0d exp 1", score); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL multi_over got %b exp 1", game_over); end
        hit_btn = 4'b0000;
    endtask

    task automatic test_held_button();
        start = 1'b0; step(3);
        start = 1'b1; exp_win = UPT; step(3 + GAPC);
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL mole6 got %b exp 0010", LEDR); end
        hit_btn = 4'b0010;
        step(3);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL held_s1 got %0d exp 1", score); end
        upd_win();
        step(GAPC);
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL mole7 got %b exp 0100", LEDR); end
        hit_btn = 4'b0110;
        step(3);
        checks++; if (score !== 8'd2) begin errors++; $display("FAIL held_s2 got %0d exp 2", score); end
        checks++; if (misses !== 4'd0) begin errors++; $display("FAIL held_miss got %0d exp 0", misses); end
        upd_win();
        hit_btn = 4'b0000;
        step(GAPC);
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL mole8 got %b exp 0010", LEDR); end
        step(exp_win * TD - 1);
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL win_hold got %b exp 0010", LEDR); end
        step(1);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL win_end got %b exp 0000", LEDR); end
        checks++; if (misses !== 4'd1) begin errors++; $display("FAIL win_miss got %0d exp 1", misses); end
        step(GAPC);
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL mole9 got %b exp 1000", LEDR); end
    endtask

`ifdef SPEEDUP_EN
    task automatic test_speedup();
        hit_btn = 4'b1000;
        step(3);
        checks++; if (score !== 8'd3) begin errors++; $display("FAIL sp_score got %0d exp 3", score); end
        upd_win();
        hit_btn = 4'b0000;
        step(GAPC);
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL mole10 got %b exp 1000", LEDR); end
        step(exp_win * TD - 1);
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL sp_hold got %b exp 1000", LEDR); end
        step(1);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL sp_end got %b exp 1", game_over); end
        start = 1'b0; step(3);
        start = 1'b1; step(3 + GAPC);
    endtask
`endif

    task automatic test_reset_mid_up();
        step(5);
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL pre_rst got %b exp 1000", LEDR); end
        #3;
        rst_n = 1'b0; start = 1'b0;
        #1;
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL arst_led got %b exp 0000", LEDR); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL arst_score got %0d exp 0", score); end
        checks++; if (misses !== 4'd0) begin errors++; $display("FAIL arst_miss got %0d exp 0", misses); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL arst_over got %b exp 0", game_over); end
        step(3);
        rst_n = 1'b1;
        step(20);
        checks++; if (LEDR !== 4'b0000) begin errors++; $display("FAIL post_idle got %b exp 0000", LEDR); end
        start = 1'b1;
        step(3 + GAPC);
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL lfsr_rst got %b exp 0100", LEDR); end
    endtask

    initial begin
        test_reset();
        test_mole_sequence();
        test_game_over();
        test_hit();
        test_wrong_press();
        test_held_button();
`ifdef SPEEDUP_EN
        test_speedup();
`endif
        test_reset_mid_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
